// File: rtl/grid_serializer.sv
// rtl/grid_serializer.sv - FIFO-buffered ROWSxCOLS grid to bit-serial stream with position tags
// Optional feature macro: GRID_PARITY_EN (appends an even-parity beat to every frame)
module grid_serializer #(
    parameter int DEPTH = 4,
    parameter int ROWS  = 2,
    parameter int COLS  = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [ROWS-1:0][COLS:1]                   in_grid,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      out_bit,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic [$clog2(COLS+1)-1:0]                 out_col,
    output logic                                      out_last,
    output logic                                      out_par,
    output logic [7:0]                                frames_done
);
    localparam int N   = ROWS * COLS;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = $clog2(COLS + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    localparam logic [RW-1:0]  ROW_TOP = RW'(ROWS - 1);
    localparam logic [CLW-1:0] COL_TOP = CLW'(COLS);
    localparam logic [CLW-1:0] COL_ONE = CLW'(1);
    localparam logic [CW-1:0]  FULL    = CW'(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [N-1:0]   in_flat;
    logic [N-1:0]   mem_q [DEPTH];
    logic [N-1:0]   mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [0:0]     state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CLW-1:0] col_q, col_d;
    logic [7:0]     frames_q, frames_d;
    logic           push, pop, beat, last_beat, fifo_empty;
`ifdef GRID_PARITY_EN
    logic           par_beat_q, par_beat_d, par_bit_q, par_bit_d;
`endif

    // Packed [ROWS-1:0][COLS:1] flattens so that the first element emitted is the MSB.
    assign in_flat = in_grid;

    always_comb begin
        in_ready   = (count_q != FULL);
        fifo_empty = (count_q == '0);
        push       = in_valid && in_ready;
        beat       = (state_q == S_SHIFT) && out_ready;
`ifdef GRID_PARITY_EN
        last_beat  = par_beat_q;
`else
        last_beat  = (row_q == '0) && (col_q == COL_ONE);
`endif
        pop        = !fifo_empty && ((state_q == S_IDLE) || (beat && last_beat));
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        sr_d     = sr_q;
        row_d    = row_q;
        col_d    = col_q;
        frames_d = frames_q;
`ifdef GRID_PARITY_EN
        par_beat_d = par_beat_q;
        par_bit_d  = par_bit_q;
`endif
        if (push) begin
            mem_d[wr_ptr_q] = in_flat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (beat) begin
            sr_d = sr_q << 1;
            if (last_beat) begin
                frames_d = frames_q + 8'd1;
                state_d  = S_IDLE;
            end else if (col_q == COL_ONE) begin
                col_d = COL_TOP;
                row_d = row_q - RW'(1);
`ifdef GRID_PARITY_EN
                if (row_q == '0) begin
                    par_beat_d = 1'b1;
                    row_d      = '0;
                    col_d      = '0;
                end
`endif
            end else begin
                col_d = col_q - CLW'(1);
            end
        end
        // A pop on the final beat reloads in the same edge, so frames run back to back.
        if (pop) begin
            sr_d    = mem_q[rd_ptr_q];
            row_d   = ROW_TOP;
            col_d   = COL_TOP;
            state_d = S_SHIFT;
`ifdef GRID_PARITY_EN
            par_beat_d = 1'b0;
            par_bit_d  = ^mem_q[rd_ptr_q];
`endif
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            sr_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            frames_q <= '0;
`ifdef GRID_PARITY_EN
            par_beat_q <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            sr_q     <= sr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            frames_q <= frames_d;
`ifdef GRID_PARITY_EN
            par_beat_q <= par_beat_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    always_comb begin
        out_valid   = (state_q == S_SHIFT);
        out_row     = out_valid ? row_q : '0;
        out_col     = out_valid ? col_q : '0;
        frames_done = frames_q;
`ifdef GRID_PARITY_EN
        out_bit  = out_valid && (par_beat_q ? par_bit_q : sr_q[N-1]);
        out_last = out_valid && par_beat_q;
        out_par  = out_valid && par_beat_q;
`else
        out_bit  = out_valid && sr_q[N-1];
        out_last = out_valid && last_beat;
        out_par  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_grid_serializer.sv
// tb/tb_grid_serializer.sv - directed self-checking bench for grid_serializer
module tb_grid_serializer;

`ifdef GRID_PARITY_EN
    localparam int BEATS = 7;
`else
    localparam int BEATS = 6;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0][3:1] in_grid = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_bit;
    logic [0:0]      out_row;
    logic [1:0]      out_col;
    logic            out_last;
    logic            out_par;
    logic [7:0]      frames_done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frames = 0;

    grid_serializer #(.DEPTH(4), .ROWS(2), .COLS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_grid     (in_grid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bit     (out_bit),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .out_par     (out_par),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grid(input logic [5:0] g, input logic exp_ready);
        check("in_ready_before_push", {31'd0, in_ready}, {31'd0, exp_ready});
        in_valid = 1'b1;
        in_grid  = g;
        step();
        in_valid = 1'b0;
    endtask

    // Checks one full frame of grid g; beat index stall_at is held with out_ready=0 for 5 cycles.
    task automatic expect_frame(input logic [5:0] g, input bit wait_first, input int stall_at);
        int w;
        int e;
        logic eb, er, el, ep;
        logic [1:0] ec;
        w = 0;
        while (wait_first && !out_valid && w < 20) begin
            step();
            w++;
        end
        for (int b = 0; b < BEATS; b++) begin
            if (b < 6) begin
                e  = 5 - b;
                eb = g[e];
                er = 1'(e / 3);
                ec = 2'(e % 3 + 1);
                el = (BEATS == 6) && (b == 5);
                ep = 1'b0;
            end else begin
                eb = ^g;
                er = 1'b0;
                ec = 2'd0;
                el = 1'b1;
                ep = 1'b1;
            end
            if (b == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    check("stall_bit", {31'd0, out_bit}, {31'd0, eb});
                    check("stall_row", {31'd0, out_row}, {31'd0, er});
                    check("stall_col", {30'd0, out_col}, {30'd0, ec});
                end
                out_ready = 1'b1;
            end
            check("beat_valid", {31'd0, out_valid}, 32'd1);
            check("beat_bit",   {31'd0, out_bit},   {31'd0, eb});
            check("beat_row",   {31'd0, out_row},   {31'd0, er});
            check("beat_col",   {30'd0, out_col},   {30'd0, ec});
            check("beat_last",  {31'd0, out_last},  {31'd0, el});
            check("beat_par",   {31'd0, out_par},   {31'd0, ep});
            step();
        end
        exp_frames = (exp_frames + 1) % 256;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) seen++;
            step();
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int pushed;
        int w;
        logic acc;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_frames",    {24'd0, frames_done}, 32'd0);
        check("rst_out_bit",   {31'd0, out_bit},   32'd0);
        check("rst_out_last",  {31'd0, out_last},  32'd0);
        check("rst_out_par",   {31'd0, out_par},   32'd0);
        check("rst_out_col",   {30'd0, out_col},   32'd0);

        // single frame and one-cycle IDLE latency
        out_ready = 1'b1;
        push_grid(6'b100_001, 1'b1);
        check("lat_k", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_k1", {31'd0, out_valid}, 32'd1);
        expect_frame(6'b100_001, 1'b0, -1);
        check("frames_after_1", {24'd0, frames_done}, exp_frames);
        check("idle_after_1", {31'd0, out_valid}, 32'd0);

        // parity-oriented patterns: all ones and a single one
        push_grid(6'b111_111, 1'b1);
        expect_frame(6'b111_111, 1'b1, -1);
        push_grid(6'b000_100, 1'b1);
        expect_frame(6'b000_100, 1'b1, -1);

        // back-pressure mid-frame
        push_grid(6'b101_101, 1'b1);
        expect_frame(6'b101_101, 1'b1, 2);
        check("frames_after_stall", {24'd0, frames_done}, exp_frames);

        // fill: first grid goes to the shifter, next four fill the FIFO, sixth is ignored
        out_ready = 1'b0;
        push_grid(6'b110_000, 1'b1);
        push_grid(6'b011_010, 1'b1);
        push_grid(6'b001_111, 1'b1);
        push_grid(6'b100_110, 1'b1);
        push_grid(6'b010_011, 1'b1);
        push_grid(6'b111_000, 1'b0);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        expect_frame(6'b110_000, 1'b1, -1);
        expect_frame(6'b011_010, 1'b0, -1);
        expect_frame(6'b001_111, 1'b0, -1);
        expect_frame(6'b100_110, 1'b0, -1);
        expect_frame(6'b010_011, 1'b0, -1);
        check("frames_after_fill", {24'd0, frames_done}, exp_frames);
        expect_quiet("ignored_grid_out", 8);

        // reset on beat 3 with two grids queued
        out_ready = 1'b0;
        push_grid(6'b111_111, 1'b1);
        push_grid(6'b101_010, 1'b1);
        push_grid(6'b010_101, 1'b1);
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst_frames",    {24'd0, frames_done}, 32'd0);
        rst = 1'b0;
        exp_frames = 0;
        expect_quiet("midrst_no_output", 12);

        // frames_done wrap after 256 frames
        pushed = 0;
        w = 0;
        while (pushed < 256 && w < 4000) begin
            in_valid = 1'b1;
            in_grid  = 6'(pushed);
            acc = in_ready;
            step();
            if (acc) pushed++;
            w++;
        end
        in_valid = 1'b0;
        check("wrap_pushed", pushed, 256);
        w = 0;
        while (out_valid && w < 4000) begin
            step();
            w++;
        end
        check("wrap_drained", {31'd0, out_valid}, 32'd0);
        check("wrap_frames_0", {24'd0, frames_done}, 32'd0);
        exp_frames = 0;
        push_grid(6'b011_001, 1'b1);
        expect_frame(6'b011_001, 1'b1, -1);
        check("wrap_frames_1", {24'd0, frames_done}, exp_frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
